// File: rtl/demux_1x8_pkg.sv
// Shared definitions for the registered 1-to-8 demultiplexer.
//   NUM_OUT  : number of routed outputs
//   SEL_W    : select width
//   sel_t    : select code type
//   onehot8  : select code -> one-hot output enable vector
package demux_pkg;
  localparam int NUM_OUT = 8;
  localparam int SEL_W   = 3;

  typedef logic [SEL_W-1:0] sel_t;

  function automatic logic [NUM_OUT-1:0] onehot8(sel_t sel);
    return NUM_OUT'(1) << sel;
  endfunction
endpackage

// File: rtl/demux_1x8_if.sv
// Bus bundle for demux_1x8.
//   I          : data word to route (N bits)
//   S0,S1,S2   : select bits, S2 is the MSB
//   Y0..Y7     : routed outputs (N bits each)
//   in_valid   : input qualifier           (DEMUX_1X8_VALID_EN only)
//   out_valid  : one-hot output qualifier  (DEMUX_1X8_VALID_EN only)
// master = traffic source/sink side, slave = demux side.
interface demux_1x8_if #(parameter int N = 32);
  logic [N-1:0] I;
  logic         S0, S1, S2;
  logic [N-1:0] Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7;
`ifdef DEMUX_1X8_VALID_EN
  logic         in_valid;
  logic [7:0]   out_valid;

  modport master (output I, S0, S1, S2, in_valid,
                  input  Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7, out_valid);
  modport slave  (input  I, S0, S1, S2, in_valid,
                  output Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7, out_valid);
`else
  modport master (output I, S0, S1, S2,
                  input  Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7);
  modport slave  (input  I, S0, S1, S2,
                  output Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7);
`endif
endinterface

// File: rtl/demux_1x8_out_reg.sv
// One registered output slice of the demux.
//   clk : clock          rst : synchronous active-high reset
//   en  : this slice is the selected destination
//   d   : data in        q   : registered data out, 0 when not selected
module demux_out_reg #(parameter int N = 32) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);
  // Unselected slices clear every cycle so they never hold stale data.
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
    else         q <= '0;
  end
endmodule

// File: rtl/demux_1x8.sv
// Registered 1-to-8 demultiplexer: I is routed to Y[{S2,S1,S0}] one cycle
// later, all other outputs load 0. No combinational input-to-output path.
//   clk : clock          rst : synchronous active-high reset
//   bus : demux_1x8_if slave (I, S0..S2, Y0..Y7 [, in_valid, out_valid])
// Optional feature macro: DEMUX_1X8_VALID_EN adds in_valid/out_valid; when
// undefined the block behaves as if in_valid were always 1.
module demux_1x8
  import demux_pkg::*;
#(
  parameter int N = 32
) (
  input  logic        clk,
  input  logic        rst,
  demux_1x8_if.slave  bus
);
  sel_t                          sel;
  logic [NUM_OUT-1:0]            en;
  logic [NUM_OUT-1:0][N-1:0]     y;

  assign sel = {bus.S2, bus.S1, bus.S0};

`ifdef DEMUX_1X8_VALID_EN
  logic [NUM_OUT-1:0] out_valid_q;

  // An invalid beat zeroes every slice, same as an unselected one.
  assign en = bus.in_valid ? onehot8(sel) : '0;

  always_ff @(posedge clk) begin
    if (rst) out_valid_q <= '0;
    else     out_valid_q <= en;
  end

  assign bus.out_valid = out_valid_q;
`else
  assign en = onehot8(sel);
`endif

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_slice
    demux_out_reg #(.N(N)) u_slice (
      .clk (clk),
      .rst (rst),
      .en  (en[k]),
      .d   (bus.I),
      .q   (y[k])
    );
  end

  assign bus.Y0 = y[0];
  assign bus.Y1 = y[1];
  assign bus.Y2 = y[2];
  assign bus.Y3 = y[3];
  assign bus.Y4 = y[4];
  assign bus.Y5 = y[5];
  assign bus.Y6 = y[6];
  assign bus.Y7 = y[7];
endmodule

// File: tb/tb_demux_1x8.sv
// Self-checking bench for demux_1x8: a 32-bit and an 8-bit instance share
// clk/rst/select; a reference model predicts every output each cycle and
// directed steps add literal expectations.
module tb_demux_1x8;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  demux_1x8_if #(.N(32)) dif ();
  demux_1x8_if #(.N(8))  dif8 ();

  demux_1x8 #(.N(32)) dut   (.clk(clk), .rst(rst), .bus(dif));
  demux_1x8 #(.N(8))  dut8  (.clk(clk), .rst(rst), .bus(dif8));

  // the narrow instance follows the wide one's select and low data byte
  assign dif8.I  = dif.I[7:0];
  assign dif8.S0 = dif.S0;
  assign dif8.S1 = dif.S1;
  assign dif8.S2 = dif.S2;
`ifdef DEMUX_1X8_VALID_EN
  assign dif8.in_valid = dif.in_valid;
`endif

  int errors = 0;
  int checks = 0;

  logic [7:0][31:0] y32;
  logic [7:0][7:0]  y8;
  assign y32 = {dif.Y7, dif.Y6, dif.Y5, dif.Y4, dif.Y3, dif.Y2, dif.Y1, dif.Y0};
  assign y8  = {dif8.Y7, dif8.Y6, dif8.Y5, dif8.Y4, dif8.Y3, dif8.Y2, dif8.Y1, dif8.Y0};

  // ---------------- reference model ----------------
  // After an edge: output k holds the data only if not reset, the beat is
  // valid and k equals the select value; everything else is zero.
  logic [31:0] m32 [8];
  logic [7:0]  m8  [8];
  logic [7:0]  mvld;
  logic        model_ok = 1'b0;
  logic        sel_bad  = 1'b0;

  always @(posedge clk) begin
    int s;
    bit v;
    s = int'({dif.S2, dif.S1, dif.S0});
`ifdef DEMUX_1X8_VALID_EN
    v = (dif.in_valid === 1'b1);
`else
    v = 1'b1;
`endif
    for (int k = 0; k < 8; k++) begin
      m32[k] <= (!rst && v && s == k) ? dif.I      : 32'd0;
      m8[k]  <= (!rst && v && s == k) ? dif.I[7:0] : 8'd0;
      mvld[k] <= (!rst && v && s == k);
    end
    sel_bad  <= !rst && $isunknown({dif.S2, dif.S1, dif.S0});
    model_ok <= 1'b1;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (model_ok) begin
      if (sel_bad) begin
        errors++;
        $display("FAIL sel_x: select had X/Z on last edge");
      end
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (y32[k] !== m32[k]) begin
          errors++;
          $display("FAIL model_y32[%0d]: got %h want %h", k, y32[k], m32[k]);
        end
        checks++;
        if (y8[k] !== m8[k]) begin
          errors++;
          $display("FAIL model_y8[%0d]: got %h want %h", k, y8[k], m8[k]);
        end
      end
`ifdef DEMUX_1X8_VALID_EN
      checks++;
      if (dif.out_valid !== mvld) begin
        errors++;
        $display("FAIL model_vld: got %b want %b", dif.out_valid, mvld);
      end
`endif
    end
  end

  // ---------------- directed literal checks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // all 32-bit outputs: slot idx must be val, others 0 (idx<0 -> all zero)
  task automatic chk_all(input string name, input int idx, input logic [31:0] val);
    for (int k = 0; k < 8; k++)
      chk($sformatf("%s_y%0d", name, k), y32[k], (k == idx) ? val : 32'd0);
  endtask

  task automatic set_sel(input logic [2:0] s);
    dif.S0 = s[0];
    dif.S1 = s[1];
    dif.S2 = s[2];
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst   = 1'b1;
    dif.I = 32'hFFFF_FFFF;
    set_sel(3'b101);
`ifdef DEMUX_1X8_VALID_EN
    dif.in_valid = 1'b1;
`endif

    // 1. reset held two cycles with live data/select
    tick(); chk_all("rst1", -1, 32'd0);
    tick(); chk_all("rst2", -1, 32'd0);
    rst = 1'b0;

    // 2. select sweep, new code every cycle
    dif.I = 32'd12321;
    for (int s = 0; s < 8; s++) begin
      set_sel(3'(s));
      tick();
      chk_all($sformatf("sweep%0d", s), s, 32'd12321);
    end

    // 3. fixed select, data then zero
    set_sel(3'b011);
    dif.I = 32'hDEAD_BEEF;
    tick(); chk_all("data_dead", 3, 32'hDEAD_BEEF);
    dif.I = 32'h0;
    tick(); chk_all("data_zero", -1, 32'd0);

    // 4. reset in the middle of a stream
    set_sel(3'b111);
    dif.I = 32'h1234;
    tick(); chk("mid_pre_y7", y32[7], 32'h1234);
    rst = 1'b1;
    tick(); chk("mid_rst_y7", y32[7], 32'h0);
    rst = 1'b0;
    tick(); chk("mid_post_y7", y32[7], 32'h1234);

    // 5. narrow instance carries the byte unchanged
    set_sel(3'b010);
    dif.I = 32'h0000_00A5;
    tick();
    for (int k = 0; k < 8; k++)
      chk($sformatf("w8_y%0d", k), 32'(y8[k]), (k == 2) ? 32'hA5 : 32'h0);

`ifdef DEMUX_1X8_VALID_EN
    // 6. valid qualifier
    dif.in_valid = 1'b0;
    set_sel(3'b100);
    dif.I = 32'd7;
    tick();
    chk("vld_off", 32'(dif.out_valid), 32'h00);
    chk_all("vld_off", -1, 32'd0);
    dif.in_valid = 1'b1;
    tick();
    chk("vld_on", 32'(dif.out_valid), 32'h10);
    chk_all("vld_on", 4, 32'd7);
`endif

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
